// File: rtl/cluster_count_reader_pkg.sv
// Shared types and defaults for the cluster point-count reader and its helpers.
package cluster_count_reader_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2,
        ST_CLEAR  = 2'd3
    } rdr_state_t;

    localparam int DEF_W       = 11;
    localparam int DEF_MIN_PTS = 10;
    localparam int DEF_MAX_PTS = 2000;
    localparam int SAT_MAX     = (1 << DEF_W) - 1;

endpackage

// File: rtl/cluster_size_classify.sv
// Combinational keep decision: count inside [MIN_PTS, MAX_PTS] and not saturated.
module cluster_size_classify
    import cluster_count_reader_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int MIN_PTS = DEF_MIN_PTS,
    parameter int MAX_PTS = DEF_MAX_PTS
) (
    input  logic [W-1:0] count_i,
    input  logic         sat_i,
    output logic         keep_o
);

    localparam logic [W-1:0] LO = W'(MIN_PTS);
    localparam logic [W-1:0] HI = W'(MAX_PTS);

    // A saturated count is not the real size, so it can never be kept.
    assign keep_o = !sat_i && (count_i >= LO) && (count_i <= HI);

endmodule

// File: rtl/cluster_count_reader.sv
// Drives the per-cluster point accumulator and reports count/keep/sat per cluster.
// Optional out_id cluster tag enabled by defining CLUSTER_COUNT_READER_ID_EN.
module cluster_count_reader
    import cluster_count_reader_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int MIN_PTS = DEF_MIN_PTS,
    parameter int MAX_PTS = DEF_MAX_PTS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic         acc_ce,
    output logic         acc_a,
    output logic         acc_rst,
    input  logic [W-1:0] acc_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_count,
    output logic         out_keep,
    output logic         out_sat
`ifdef CLUSTER_COUNT_READER_ID_EN
    ,
    output logic [7:0]   out_id
`endif
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    rdr_state_t   state_q, state_d;
    logic         sat_q, sat_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_count_q, out_count_d;
    logic         out_keep_q, out_keep_d;
    logic         out_sat_q, out_sat_d;
    logic         keep_w;

    cluster_size_classify #(
        .W       (W),
        .MIN_PTS (MIN_PTS),
        .MAX_PTS (MAX_PTS)
    ) u_classify (
        .count_i (acc_y),
        .sat_i   (sat_q),
        .keep_o  (keep_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_keep_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_keep_q  <= out_keep_d;
            out_sat_q   <= out_sat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_keep_d  = out_keep_q;
        out_sat_d   = out_sat_q;
        in_ready    = 1'b0;
        acc_ce      = 1'b0;
        acc_a       = 1'b0;
        acc_rst     = 1'b0;

        unique case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Points past the top of the counter are swallowed, not counted.
                    if (acc_y != CNT_MAX) begin
                        acc_ce = 1'b1;
                        acc_a  = 1'b1;
                    end else begin
                        sat_d = 1'b1;
                    end
                    if (in_last) state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // acc_y now includes the final point.
                out_count_d = acc_y;
                out_keep_d  = keep_w;
                out_sat_d   = sat_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                acc_rst = 1'b1;
                sat_d   = 1'b0;
                state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase

        // Reset clears the accumulator in the same cycle and blocks any count.
        if (rst) begin
            in_ready = 1'b0;
            acc_ce   = 1'b0;
            acc_a    = 1'b0;
            acc_rst  = 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_keep  = out_keep_q;
    assign out_sat   = out_sat_q;

`ifdef CLUSTER_COUNT_READER_ID_EN
    logic [7:0] id_cnt_q;
    logic [7:0] out_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_cnt_q <= 8'd0;
            out_id_q <= 8'd0;
        end else begin
            if (state_q == ST_SETTLE) out_id_q <= id_cnt_q;
            if (state_q == ST_OUT && out_valid_q && out_ready) id_cnt_q <= id_cnt_q + 8'd1;
        end
    end

    assign out_id = out_id_q;
`endif

endmodule

// File: tb/tb_cluster_count_reader.sv
// Directed bench for cluster_count_reader with a behavioural accumulator alongside.
module tb_cluster_count_reader;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_last, in_ready;
    logic         acc_ce, acc_a, acc_rst;
    logic [W-1:0] acc_y = '0;
    logic         out_valid, out_ready;
    logic [W-1:0] out_count;
    logic         out_keep, out_sat;
`ifdef CLUSTER_COUNT_READER_ID_EN
    logic [7:0]   out_id;
`endif

    int errors = 0;
    int checks = 0;

    // running monitor totals; the main thread only takes differences
    int vld_tot = 0, arst_tot = 0, both_bad = 0, ce_sat_bad = 0;

    always #5 clk = ~clk;

    cluster_count_reader #(.W(W), .MIN_PTS(10), .MAX_PTS(2000)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .acc_ce    (acc_ce),
        .acc_a     (acc_a),
        .acc_rst   (acc_rst),
        .acc_y     (acc_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_keep  (out_keep),
        .out_sat   (out_sat)
`ifdef CLUSTER_COUNT_READER_ID_EN
        ,
        .out_id    (out_id)
`endif
    );

    // accumulator: registered count, sync clear, 1-edge latency
    always @(posedge clk) begin
        if (acc_rst)     acc_y <= '0;
        else if (acc_ce) acc_y <= acc_y + {{(W-1){1'b0}}, acc_a};
    end

    always @(negedge clk) begin
        if (out_valid) vld_tot++;
        if (acc_rst) arst_tot++;
        if (acc_rst && acc_ce) both_bad++;
        if (acc_ce && acc_y == {W{1'b1}}) ce_sat_bad++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_points(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = with_last && (i == n - 1);
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) chk("accept_timeout", 0, 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    typedef struct {
        int npts;
        int exp_count;
        int exp_keep;
        int exp_sat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int v0, r0, bad;

        vecs[0] = '{15,   15,   1, 0};
        vecs[1] = '{1,    1,    0, 0};
        vecs[2] = '{2000, 2000, 1, 0};
        vecs[3] = '{2001, 2001, 0, 0};
        vecs[4] = '{2100, 2047, 0, 1};
        vecs[5] = '{9,    9,    0, 0};
        vecs[6] = '{10,   10,   1, 0};
        vecs[7] = '{2047, 2047, 0, 0};
        vecs[8] = '{2048, 2047, 0, 1};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),  0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_keep",  int'(out_keep),  0);
        chk("rst_out_sat",   int'(out_sat),   0);
        chk("rst_acc_ce",    int'(acc_ce),    0);
        chk("rst_acc_rst",   int'(acc_rst),   1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);

        for (int k = 0; k < 9; k++) begin
            v0 = vld_tot; r0 = arst_tot;
            chk($sformatf("v%0d_start_acc", k), int'(acc_y), 0);
            send_points(vecs[k].npts, 1'b1);
            wait_out();
            chk($sformatf("v%0d_count", k), int'(out_count), vecs[k].exp_count);
            chk($sformatf("v%0d_keep", k),  int'(out_keep),  vecs[k].exp_keep);
            chk($sformatf("v%0d_sat", k),   int'(out_sat),   vecs[k].exp_sat);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_valid_cycles", k), vld_tot - v0, 1);
            chk($sformatf("v%0d_acc_rst_pulses", k), arst_tot - r0, 1);
        end

        // back-pressure: result held 20 cycles while upstream keeps pushing
        out_ready = 1'b0;
        send_points(5, 1'b1);
        in_valid = 1'b1; in_last = 1'b1;
        wait_out();
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready || !out_valid || out_count != 11'd5 || out_keep || out_sat || acc_ce) bad++;
        end
        chk("stall_bad_cycles", bad, 0);
        out_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_next_acc_zero", int'(acc_y), 0);
        send_points(3, 1'b1);
        wait_out();
        chk("stall_next_count", int'(out_count), 3);
        repeat (3) @(negedge clk);

        // reset after 7 points of an open cluster
        send_points(7, 1'b0);
        chk("mid_acc_seven", int'(acc_y), 7);
        rst = 1'b1;
        #1;
        chk("mid_rst_acc_rst", int'(acc_rst), 1);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_acc_cleared", int'(acc_y), 0);
        send_points(3, 1'b1);
        wait_out();
        chk("mid_rst_next_count", int'(out_count), 3);
        repeat (3) @(negedge clk);

        // reset while a result is pending drops it
        out_ready = 1'b0;
        send_points(4, 1'b1);
        wait_out();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("out_rst_dropped", int'(out_valid), 0);
        chk("out_rst_acc_zero", int'(acc_y), 0);
        out_ready = 1'b1;

`ifdef CLUSTER_COUNT_READER_ID_EN
        bad = 0;
        for (int k = 0; k < 257; k++) begin
            send_points(1, 1'b1);
            wait_out();
            if (out_id != 8'(k)) begin
                bad++;
                $display("FAIL id_seq: got %0d expected %0d", out_id, k % 256);
            end
        end
        chk("id_seq_errors", bad, 0);
        repeat (3) @(negedge clk);
`endif

        chk("never_ce_and_rst", both_bad, 0);
        chk("no_ce_at_sat", ce_sat_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
